// File: rtl/cache_refill_ctrl_if.sv
// Refill controller bundle: miss-handler request, bus beat stream, cacheram write port, completion.
// Forwarding signals exist only when CACHE_REFILL_FWD_EN is defined.
interface cache_refill_ctrl_if #(
    parameter int DEEPTH     = 2048,
    parameter int BYTE_NUM   = 16,
    parameter int BEAT_BYTES = 8,
    parameter int LINE_ROWS  = 4
);
    localparam int AW    = $clog2(DEEPTH);
    localparam int R     = BYTE_NUM / BEAT_BYTES;
    localparam int BEATS = LINE_ROWS * R;
    localparam int BW    = $clog2(BEATS);
    localparam int IW    = AW - $clog2(LINE_ROWS);

    logic                    req_valid;
    logic                    req_ready;
    logic [IW-1:0]           req_index;
    logic [BW-1:0]           req_beat;
    logic                    beat_valid;
    logic                    beat_ready;
    logic [BEAT_BYTES*8-1:0] beat_data;
    logic                    beat_last;
    logic                    beat_err;
    logic [AW-1:0]           ram_addr;
    logic                    ram_ce;
    logic                    ram_we;
    logic [BYTE_NUM-1:0]     ram_bsel;
    logic [BYTE_NUM*8-1:0]   ram_dataw;
    logic                    done;
    logic                    done_err;
`ifdef CACHE_REFILL_FWD_EN
    logic                    fwd_valid;
    logic [BEAT_BYTES*8-1:0] fwd_data;
`endif

    modport master (
        output req_valid, req_index, req_beat, beat_valid, beat_data, beat_last, beat_err,
`ifdef CACHE_REFILL_FWD_EN
        input  fwd_valid, fwd_data,
`endif
        input  req_ready, beat_ready, ram_addr, ram_ce, ram_we, ram_bsel, ram_dataw,
               done, done_err
    );

    modport slave (
        input  req_valid, req_index, req_beat, beat_valid, beat_data, beat_last, beat_err,
`ifdef CACHE_REFILL_FWD_EN
        output fwd_valid, fwd_data,
`endif
        output req_ready, beat_ready, ram_addr, ram_ce, ram_we, ram_bsel, ram_dataw,
               done, done_err
    );
endinterface

// File: rtl/cache_refill_ctrl.sv
// Cache line refill sequencer: wrap-order bus beats into cacheram rows/byte lanes, then done pulse.
// Optional critical-beat forwarding enabled by defining CACHE_REFILL_FWD_EN.
module cache_refill_ctrl #(
    parameter int DEEPTH     = 2048,
    parameter int BYTE_NUM   = 16,
    parameter int BEAT_BYTES = 8,
    parameter int LINE_ROWS  = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    cache_refill_ctrl_if.slave bus
);
    localparam int AW    = $clog2(DEEPTH);
    localparam int R     = BYTE_NUM / BEAT_BYTES;
    localparam int BEATS = LINE_ROWS * R;
    localparam int BW    = $clog2(BEATS);
    localparam int RW    = $clog2(LINE_ROWS);
    localparam int IW    = AW - RW;
    localparam int DW    = BEAT_BYTES * 8;
    localparam logic [BYTE_NUM-1:0] LANE_MASK = BYTE_NUM'({BEAT_BYTES{1'b1}});

    typedef enum logic [1:0] {S_IDLE, S_FILL, S_FLUSH, S_DONE} state_e;

    state_e              r_state;
    state_e              w_next_state;
    logic [IW-1:0]       r_index;
    logic [BW-1:0]       r_ptr;
    logic [BW-1:0]       r_cnt;
    logic                r_err;

    logic                r_ram_ce;
    logic                r_ram_we;
    logic [AW-1:0]       r_ram_addr;
    logic [BYTE_NUM-1:0] r_ram_bsel;
    logic [BYTE_NUM*8-1:0] r_ram_dataw;

    logic                w_beat_acc;
    logic                w_final_beat;
    logic                w_last_bad;
    logic                w_write;
    logic [BW-1:0]       w_ptr_nxt;
    logic [RW-1:0]       w_row;
    logic [BYTE_NUM-1:0] w_bsel;

    assign w_beat_acc   = (r_state == S_FILL) && bus.beat_valid;
    assign w_final_beat = (r_cnt == BW'(BEATS - 1));
    assign w_last_bad   = (bus.beat_last != w_final_beat);
    assign w_write      = w_beat_acc && !bus.beat_err;
    assign w_ptr_nxt    = (r_ptr == BW'(BEATS - 1)) ? '0 : r_ptr + 1'b1;
    assign w_row        = RW'(32'(r_ptr) / R);
    assign w_bsel       = LANE_MASK << ((32'(r_ptr) % R) * BEAT_BYTES);

    // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= S_IDLE;
        else        r_state <= w_next_state;
    end

    // NOTE: default assignment first so no path leaves the signal unassigned (no latch).
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE:  if (bus.req_valid) w_next_state = S_FILL;
            S_FILL:  if (w_beat_acc && w_final_beat) w_next_state = S_FLUSH;
            S_FLUSH: w_next_state = S_DONE;
            S_DONE:  w_next_state = S_IDLE;
            default: w_next_state = S_IDLE;
        endcase
    end

    always_comb begin
        bus.req_ready  = (r_state == S_IDLE);
        bus.beat_ready = (r_state == S_FILL);
        bus.done       = (r_state == S_DONE);
        bus.done_err   = (r_state == S_DONE) && r_err;
    end

    // Termination is by beat count only; a misplaced beat_last is just flagged.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_index <= '0;
            r_ptr   <= '0;
            r_cnt   <= '0;
            r_err   <= 1'b0;
        end else if (r_state == S_IDLE && bus.req_valid) begin
            r_index <= bus.req_index;
            r_ptr   <= bus.req_beat;
            r_cnt   <= '0;
            r_err   <= 1'b0;
        end else if (w_beat_acc) begin
            r_ptr   <= w_ptr_nxt;
            r_cnt   <= r_cnt + 1'b1;
            r_err   <= r_err | bus.beat_err | w_last_bad;
        end
    end

    // Address and data hold between writes; only the strobes and lane mask return to zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ram_ce    <= 1'b0;
            r_ram_we    <= 1'b0;
            r_ram_addr  <= '0;
            r_ram_bsel  <= '0;
            r_ram_dataw <= '0;
        end else if (w_write) begin
            r_ram_ce    <= 1'b1;
            r_ram_we    <= 1'b1;
            r_ram_addr  <= {r_index, w_row};
            r_ram_bsel  <= w_bsel;
            r_ram_dataw <= {R{bus.beat_data}};
        end else begin
            r_ram_ce    <= 1'b0;
            r_ram_we    <= 1'b0;
            r_ram_bsel  <= '0;
        end
    end

    assign bus.ram_ce    = r_ram_ce;
    assign bus.ram_we    = r_ram_we;
    assign bus.ram_addr  = r_ram_addr;
    assign bus.ram_bsel  = r_ram_bsel;
    assign bus.ram_dataw = r_ram_dataw;

`ifdef CACHE_REFILL_FWD_EN
    logic          r_fwd_valid;
    logic [DW-1:0] r_fwd_data;
    logic          w_fwd;

    // The first accepted beat is always the critical one.
    assign w_fwd = w_write && (r_cnt == '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_fwd_valid <= 1'b0;
            r_fwd_data  <= '0;
        end else begin
            r_fwd_valid <= w_fwd;
            r_fwd_data  <= w_fwd ? bus.beat_data : '0;
        end
    end

    assign bus.fwd_valid = r_fwd_valid;
    assign bus.fwd_data  = r_fwd_data;
`endif
endmodule

// File: tb/tb_cache_refill_ctrl.sv
// Scoreboard bench for cache_refill_ctrl: randomized refills vs. a line/beat arithmetic model.
module tb_cache_refill_ctrl;
    localparam int DEEPTH = 2048, BYTE_NUM = 16, BEAT_BYTES = 8, LINE_ROWS = 4;
    localparam int AW = 11, IW = 9, BW = 3, R = 2, BEATS = 8, DW = 64, RDW = 128;

    typedef struct {
        logic [AW-1:0]       addr;
        logic [BYTE_NUM-1:0] bsel;
        logic [RDW-1:0]      data;
    } wr_t;
    typedef struct {
        bit err;
        int lat;
    } dn_t;

    logic clk;
    logic rst_n;
    cache_refill_ctrl_if #(.DEEPTH(DEEPTH), .BYTE_NUM(BYTE_NUM), .BEAT_BYTES(BEAT_BYTES),
                           .LINE_ROWS(LINE_ROWS)) bus ();

    cache_refill_ctrl #(.DEEPTH(DEEPTH), .BYTE_NUM(BYTE_NUM), .BEAT_BYTES(BEAT_BYTES),
                        .LINE_ROWS(LINE_ROWS)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int          n_cmp = 0;
    int          n_bad = 0;
    wr_t         wq[$];
    dn_t         dq[$];
    logic [DW-1:0] fq[$];
    time         t_acc;
    bit          mon_en = 0;

    task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: every RAM write and done pulse must match the head of its queue.
    wr_t           mon_w;
    dn_t           mon_d;
    logic [DW-1:0] mon_f;
    always @(negedge clk) begin
        if (mon_en) begin
            check("we_eq_ce", bus.ram_we, bus.ram_ce);
            if (bus.ram_ce) begin
                check("wr_pending", 256'(wq.size() > 0), 1);
                if (wq.size() > 0) begin
                    mon_w = wq.pop_front();
                    check("ram_addr", bus.ram_addr, mon_w.addr);
                    check("ram_bsel", bus.ram_bsel, mon_w.bsel);
                    check("ram_dataw", bus.ram_dataw, mon_w.data);
                end
            end else begin
                check("idle_bsel", bus.ram_bsel, 0);
            end
            if (bus.done) begin
                check("done_pending", 256'(dq.size() > 0), 1);
                if (dq.size() > 0) begin
                    mon_d = dq.pop_front();
                    check("done_err", bus.done_err, mon_d.err);
                    if (mon_d.lat > 0) check("done_latency", 256'(($time - t_acc) / 10), mon_d.lat);
                end
            end
`ifdef CACHE_REFILL_FWD_EN
            if (bus.fwd_valid) begin
                check("fwd_pending", 256'(fq.size() > 0), 1);
                if (fq.size() > 0) begin
                    mon_f = fq.pop_front();
                    check("fwd_data", bus.fwd_data, mon_f);
                    check("fwd_with_write", bus.ram_ce, 1);
                    check("fwd_eq_ram", bus.fwd_data, bus.ram_dataw[DW-1:0]);
                end
            end else begin
                check("fwd_data_idle", bus.fwd_data, 0);
            end
`endif
        end
    end

    // gap_mode: 0 back-to-back, 1 two idle cycles between beats, 2 random 0..2 idle cycles.
    // err_k / last_k / abort_k: beat position for bus error, beat_last, reset (-1 = none / normal).
    task automatic refill(input int idx, input int b, input int gap_mode, input int err_k,
                          input int last_k, input int abort_k);
        bit            exp_err;
        logic [DW-1:0] d;
        int            p;
        int            gaps;
        wr_t           w;
        dn_t           dn;
        exp_err = 1'b0;
        @(negedge clk);
        check("req_ready_idle", bus.req_ready, 1);
        bus.req_valid = 1'b1;
        bus.req_index = IW'(idx);
        bus.req_beat  = BW'(b);
        @(negedge clk);
        bus.req_valid = 1'b0;
        t_acc = $time;
        for (int k = 0; k < BEATS; k++) begin
            gaps = (gap_mode == 1) ? 2 : (gap_mode == 2) ? int'($urandom_range(0, 2)) : 0;
            if (k > 0) repeat (gaps) @(negedge clk);
            p = (b + k) % BEATS;
            d = {$urandom, $urandom};
            bus.beat_valid = 1'b1;
            bus.beat_data  = d;
            bus.beat_err   = (k == err_k);
            bus.beat_last  = (last_k < 0) ? (k == BEATS - 1) : (k == last_k);
            if (bus.beat_err) exp_err = 1'b1;
            if (bus.beat_last != (k == BEATS - 1)) exp_err = 1'b1;
            if (k == abort_k) begin
                #2 rst_n = 1'b0;
                #1;
                check("abort_ram_ce", bus.ram_ce, 0);
                check("abort_ram_we", bus.ram_we, 0);
                check("abort_beat_ready", bus.beat_ready, 0);
                check("abort_req_ready", bus.req_ready, 1);
                wq.delete();
                fq.delete();
                bus.beat_valid = 1'b0;
                bus.beat_err   = 1'b0;
                bus.beat_last  = 1'b0;
                repeat (3) @(negedge clk);
                #2 rst_n = 1'b1;
                return;
            end
            if (!bus.beat_err) begin
                w.addr = AW'(idx * LINE_ROWS + p / R);
                w.bsel = 16'h00FF << ((p % R) * 8);
                w.data = {d, d};
                wq.push_back(w);
`ifdef CACHE_REFILL_FWD_EN
                if (k == 0) fq.push_back(d);
`endif
            end
            @(negedge clk);
            bus.beat_valid = 1'b0;
            bus.beat_err   = 1'b0;
            bus.beat_last  = 1'b0;
        end
        dn.err = exp_err;
        dn.lat = (gap_mode == 0) ? BEATS + 1 : 0;
        dq.push_back(dn);
        for (int i = 0; i < 60 && (wq.size() + dq.size() + fq.size()) > 0; i++) @(negedge clk);
        check("drain", 256'(wq.size() + dq.size() + fq.size()), 0);
    endtask

    initial begin
        rst_n          = 1'b0;
        bus.req_valid  = 1'b0;
        bus.req_index  = '0;
        bus.req_beat   = '0;
        bus.beat_valid = 1'b0;
        bus.beat_data  = '0;
        bus.beat_last  = 1'b0;
        bus.beat_err   = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_req_ready", bus.req_ready, 1);
        check("rst_beat_ready", bus.beat_ready, 0);
        check("rst_ram_ce", bus.ram_ce, 0);
        check("rst_ram_addr", bus.ram_addr, 0);
        check("rst_ram_dataw", bus.ram_dataw, 0);
        check("rst_done", bus.done, 0);
        #2 rst_n = 1'b1;
        mon_en = 1'b1;

        refill(5, 0, 0, -1, -1, -1);      // rows 20..23, alternating lanes
        refill(1, 6, 0, -1, -1, -1);      // wrap 7 -> 0
        refill(9, 2, 1, -1, -1, -1);      // backpressure gaps
        refill(3, 0, 0, 2, -1, -1);       // error on 3rd beat
        refill(3, 1, 0, -1, -1, -1);      // error flag cleared
        refill(7, 5, 0, -1, 3, -1);       // early beat_last
        refill(11, 0, 0, -1, BEATS, -1);  // beat_last never asserted
        refill(12, 4, 0, -1, -1, 4);      // reset during 5th beat
        refill(12, 4, 0, -1, -1, -1);     // clean refill after reset
        refill(40, 3, 0, -1, -1, -1);     // critical beat 3 -> row idx*4+1, upper lanes
        refill(41, 3, 0, 0, -1, -1);      // errored critical beat

        for (int n = 0; n < 12; n++) begin
            refill(int'($urandom_range(0, (1 << IW) - 1)), int'($urandom_range(0, BEATS - 1)),
                   int'($urandom_range(0, 2)),
                   ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, BEATS - 1)) : -1,
                   ($urandom_range(0, 4) == 0) ? int'($urandom_range(0, BEATS)) : -1, -1);
        end

        repeat (3) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
